// File: rtl/imem_access_ctrl.sv
// -----------------------------------------------------------------------------
// imem_access_ctrl
//
// Sequencing controller and arbiter for the single-port instruction memory
// behind the fetch stage. It shares the memory between fetch reads and the
// boot/program-loader write port. It hides the fixed memory read latency by
// raising the fetch stall. It drops in-flight fetches when a branch/jump
// redirect resolves in Execute.
//
// Handshakes:
//   fetch_req is a level request. The controller answers it with a one-cycle
//   instr_valid pulse, and stall_f is high for every cycle that fetch_req is
//   high and instr_valid is not.
//   ldr_req is a level request held until the one-cycle ldr_ack pulse. A
//   write is issued (mem_en=1, mem_we=1) in the grant cycle, and ldr_ack
//   follows in the next cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch_req/addr    fetch request and PC (PCF)
//   redirect          PCSrcE; kills the outstanding fetch
//   ldr_req/addr/wdata, ldr_ack   loader write port
//   mem_en/we/addr/wdata, mem_rdata   instruction memory interface
//   instr_out, instr_valid        fetched instruction and its valid pulse
//   stall_f           fetch stall (StallF)
//   dbg_state         current FSM state (IDLE=0, FETCH=1, KILL=2, WRITE=3)
// -----------------------------------------------------------------------------
module imem_access_ctrl #(
    parameter int MEM_LATENCY = 2,   // legal range 1..7
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              redirect,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic              stall_f,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_KILL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic        r_rr_ldr;       // 1: loader has priority on a tie
    logic [31:0] r_instr_out;
    logic        r_instr_valid;

    logic        w_fetch_ok;
    logic        w_grant_f;
    logic        w_grant_l;
    logic        w_capture;

    // A fetch may not issue while a redirect is pending, or in the cycle its
    // previous result is presented. In that cycle the fetch stage is still
    // holding the old PC.
    assign w_fetch_ok = fetch_req & ~redirect & ~r_instr_valid & ~rst;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_grant_f  = 1'b0;
        w_grant_l  = 1'b0;
        w_capture  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ldr_ack    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The loader wins if it is alone, or if it holds the priority.
                if (ldr_req && !rst && (!w_fetch_ok || r_rr_ldr)) begin
                    w_grant_l = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {ldr_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata = ldr_wdata;
                    w_next    = S_WRITE;
                end else if (w_fetch_ok) begin
                    w_grant_f  = 1'b1;
                    mem_en     = 1'b1;
                    mem_addr   = {fetch_addr[ADDR_W-1:2], 2'b00};
                    w_cnt_next = LAT;
                    w_next     = S_FETCH;
                end
            end

            S_FETCH: begin
                w_cnt_next = r_cnt - 3'd1;
                // r_cnt==1 is the cycle mem_rdata is valid (counter reaches 0).
                if (r_cnt == 3'd1) begin
                    w_next    = S_IDLE;
                    w_capture = ~redirect;
                end else if (redirect) begin
                    w_next = S_KILL;
                end
            end

            S_KILL: begin
                // Let the killed read drain so only one access is outstanding.
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_next = S_IDLE;
                end
            end

            S_WRITE: begin
                ldr_ack = 1'b1;
                w_next  = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 3'd0;
            r_rr_ldr      <= 1'b1;
            r_instr_out   <= 32'd0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_instr_valid <= w_capture;
            if (w_capture) begin
                r_instr_out <= mem_rdata;
            end
            if (w_grant_l) begin
                r_rr_ldr <= 1'b0;
            end else if (w_grant_f) begin
                r_rr_ldr <= 1'b1;
            end
        end
    end

    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign stall_f     = fetch_req & ~r_instr_valid & ~rst;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;

  localparam int ADDR_W = 32;
  localparam logic [31:0] RD_KEY = 32'h0050_0083;  // memory word = addr ^ RD_KEY
  localparam logic [31:0] RD_BAD = 32'hBAD0_BAD0;  // read data outside its valid cycle

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              redirect;
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              stall_f;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  imem_access_ctrl #(.MEM_LATENCY(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .redirect(redirect),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
    .stall_f(stall_f), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: read data valid exactly 2 cycles after issue
  logic [1:0]  rd_v;
  logic [31:0] rd_a0, rd_a1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v  <= 2'b00;
      rd_a0 <= '0;
      rd_a1 <= '0;
    end else begin
      rd_v  <= {rd_v[0], mem_en & ~mem_we};
      rd_a0 <= mem_addr;
      rd_a1 <= rd_a0;
    end
  end
  assign mem_rdata = rd_v[1] ? (rd_a1 ^ RD_KEY) : RD_BAD;

  // checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: advance to the next cycle; inputs change 2ns after the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 0; fetch_addr = '0; redirect = 0;
    ldr_req = 0; ldr_addr = '0; ldr_wdata = '0;
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_instr",  instr_out,        32'd0);
    chk("rst_mem_en", 32'(mem_en),      32'd0);
    chk("rst_ack",    32'(ldr_ack),     32'd0);
    chk("rst_state",  32'(dbg_state),   32'd0);
    rst = 1'b0;

    // basic fetch
    cyc(); fetch_req = 1; fetch_addr = 32'h10; #1;
    chk("b0_mem_en", 32'(mem_en), 1); chk("b0_we", 32'(mem_we), 0);
    chk("b0_addr", mem_addr, 32'h10); chk("b0_stall", 32'(stall_f), 1);
    cyc(); #1;
    chk("b1_mem_en", 32'(mem_en), 0); chk("b1_stall", 32'(stall_f), 1);
    chk("b1_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("b2_stall", 32'(stall_f), 1); chk("b2_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("b3_valid", 32'(instr_valid), 1); chk("b3_instr", instr_out, 32'h0050_0093);
    chk("b3_stall", 32'(stall_f), 0); chk("b3_mem_en", 32'(mem_en), 0);
    fetch_req = 0;
    cyc(); #1;
    chk("b4_valid", 32'(instr_valid), 0);

    // misaligned fetch address
    cyc(); fetch_req = 1; fetch_addr = 32'h13; #1;
    chk("m0_addr", mem_addr, 32'h10);
    cyc(); cyc(); cyc(); #1;
    chk("m3_valid", 32'(instr_valid), 1); chk("m3_instr", instr_out, 32'h0050_0093);
    fetch_req = 0;

    // redirect one cycle after issue
    cyc(); fetch_req = 1; fetch_addr = 32'h20; #1;
    chk("k0_mem_en", 32'(mem_en), 1);
    cyc(); redirect = 1; #1;
    chk("k1_mem_en", 32'(mem_en), 0);
    cyc(); redirect = 0; fetch_addr = 32'h24; #1;
    chk("k2_state", 32'(dbg_state), 2); chk("k2_mem_en", 32'(mem_en), 0);
    chk("k2_stall", 32'(stall_f), 1);
    cyc(); #1;
    chk("k3_valid", 32'(instr_valid), 0); chk("k3_instr_kept", instr_out, 32'h0050_0093);
    chk("k3_mem_en", 32'(mem_en), 1); chk("k3_addr", mem_addr, 32'h24);
    cyc(); #1; chk("k4_valid", 32'(instr_valid), 0);
    cyc(); #1; chk("k5_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("k6_valid", 32'(instr_valid), 1); chk("k6_instr", instr_out, 32'h0050_00A7);
    fetch_req = 0;

    // redirect in the capture cycle
    cyc(); fetch_req = 1; fetch_addr = 32'h30; #1;
    chk("c0_mem_en", 32'(mem_en), 1);
    cyc();
    cyc(); redirect = 1; #1;
    chk("c2_valid", 32'(instr_valid), 0);
    cyc(); redirect = 0; fetch_addr = 32'h34; #1;
    chk("c3_valid", 32'(instr_valid), 0); chk("c3_instr_kept", instr_out, 32'h0050_00A7);
    chk("c3_mem_en", 32'(mem_en), 1); chk("c3_addr", mem_addr, 32'h34);
    cyc(); cyc(); cyc(); #1;
    chk("c6_valid", 32'(instr_valid), 1); chk("c6_instr", instr_out, 32'h0050_00B7);
    fetch_req = 0;

    // simultaneous requests after reset: loader first, then alternate
    do_reset();
    cyc(); fetch_req = 1; fetch_addr = 32'h50;
    ldr_req = 1; ldr_addr = 32'h40; ldr_wdata = 32'hDEAD_BEEF; #1;
    chk("s0_mem_en", 32'(mem_en), 1); chk("s0_we", 32'(mem_we), 1);
    chk("s0_addr", mem_addr, 32'h40); chk("s0_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s0_ack", 32'(ldr_ack), 0);
    cyc(); ldr_addr = 32'h44; ldr_wdata = 32'h1234_5678; #1;
    chk("s1_ack", 32'(ldr_ack), 1); chk("s1_state", 32'(dbg_state), 3);
    chk("s1_mem_en", 32'(mem_en), 0);
    cyc(); #1;
    chk("s2_mem_en", 32'(mem_en), 1); chk("s2_we", 32'(mem_we), 0);
    chk("s2_addr", mem_addr, 32'h50); chk("s2_ack", 32'(ldr_ack), 0);
    cyc(); #1; chk("s3_mem_en", 32'(mem_en), 0);
    cyc(); #1; chk("s4_mem_en", 32'(mem_en), 0);
    cyc(); fetch_addr = 32'h54; #1;
    chk("s5_valid", 32'(instr_valid), 1); chk("s5_instr", instr_out, 32'h0050_00D3);
    chk("s5_we", 32'(mem_we), 1); chk("s5_addr", mem_addr, 32'h44);
    chk("s5_wdata", mem_wdata, 32'h1234_5678);
    cyc(); ldr_req = 0; #1;
    chk("s6_ack", 32'(ldr_ack), 1);
    cyc(); #1;
    chk("s7_mem_en", 32'(mem_en), 1); chk("s7_we", 32'(mem_we), 0);
    chk("s7_addr", mem_addr, 32'h54);
    cyc(); cyc(); cyc(); #1;
    chk("s10_valid", 32'(instr_valid), 1); chk("s10_instr", instr_out, 32'h0050_00D7);
    fetch_req = 0;

    // loader request arriving during a fetch waits for it
    cyc(); fetch_req = 1; fetch_addr = 32'h60; #1;
    chk("l0_mem_en", 32'(mem_en), 1);
    cyc(); ldr_req = 1; ldr_addr = 32'h83; ldr_wdata = 32'hA5A5_0001; #1;
    chk("l1_mem_en", 32'(mem_en), 0);
    cyc(); #1;
    chk("l2_mem_en", 32'(mem_en), 0);
    cyc(); #1;
    chk("l3_valid", 32'(instr_valid), 1); chk("l3_instr", instr_out, 32'h0050_00E3);
    chk("l3_mem_en", 32'(mem_en), 1); chk("l3_we", 32'(mem_we), 1);
    chk("l3_addr", mem_addr, 32'h80); chk("l3_wdata", mem_wdata, 32'hA5A5_0001);
    fetch_req = 0;
    cyc(); #1;
    chk("l4_ack", 32'(ldr_ack), 1);
    ldr_req = 0;
    cyc(); #1;
    chk("l5_ack", 32'(ldr_ack), 0); chk("l5_mem_en", 32'(mem_en), 0);

    // asynchronous reset in the middle of a fetch
    cyc(); fetch_req = 1; fetch_addr = 32'h70; #1;
    chk("r0_mem_en", 32'(mem_en), 1);
    cyc(); #2; rst = 1; #1;
    chk("r1_stall", 32'(stall_f), 0); chk("r1_valid", 32'(instr_valid), 0);
    chk("r1_mem_en", 32'(mem_en), 0); chk("r1_instr", instr_out, 32'd0);
    chk("r1_state", 32'(dbg_state), 0);
    cyc(); rst = 0; fetch_addr = 32'h74; #1;
    chk("r2_mem_en", 32'(mem_en), 1); chk("r2_addr", mem_addr, 32'h74);
    cyc(); cyc(); #1;
    chk("r4_valid", 32'(instr_valid), 0);
    cyc(); #1;
    chk("r5_valid", 32'(instr_valid), 1); chk("r5_instr", instr_out, 32'h0050_00F7);
    fetch_req = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
